// File: rtl/data_bus_pkg.sv
// Shared constants for the data-side bus fabric: register offsets, CTRL bit
// positions, the default register-bank base and the offset decoder.
package data_bus_pkg;

  localparam logic [15:0] DEFAULT_MMIO_BASE = 16'hBFD0;

  localparam logic [7:0] OFF_LED     = 8'h00;
  localparam logic [7:0] OFF_SW      = 8'h04;
  localparam logic [7:0] OFF_COUNT   = 8'h08;
  localparam logic [7:0] OFF_CMP     = 8'h0C;
  localparam logic [7:0] OFF_CTRL    = 8'h10;
  localparam logic [7:0] OFF_SCRATCH = 8'h14;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_CLR   = 1;
  localparam int CTRL_FLAG  = 2;
  localparam int CTRL_IRQEN = 3;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_RAM,
    SEL_LED,
    SEL_SW,
    SEL_COUNT,
    SEL_CMP,
    SEL_CTRL,
    SEL_SCRATCH
  } bus_sel_e;

  // Word-aligned offset inside the register bank to target register.
  function automatic bus_sel_e decode_offset(input logic [7:0] off);
    case (off)
      OFF_LED:     return SEL_LED;
      OFF_SW:      return SEL_SW;
      OFF_COUNT:   return SEL_COUNT;
      OFF_CMP:     return SEL_CMP;
      OFF_CTRL:    return SEL_CTRL;
      OFF_SCRATCH: return SEL_SCRATCH;
      default:     return SEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mmio_timer.sv
// 32-bit compare timer with prescaler, match flag and level interrupt.
// Driven by pre-decoded write strobes from the bus fabric.
module mmio_timer
  import data_bus_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] wdata,
  input  logic        count_we,
  input  logic        cmp_we,
  input  logic        ctrl_we,
  output logic [31:0] count,
  output logic [31:0] cmp,
  output logic [31:0] ctrl,
  output logic        irq
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre;
  logic          en;
  logic          clr_on_match;
  logic          irq_en;
  logic          flag;
  logic          tick;
  logic          match;

  // Tick and match use the registered CTRL, so a CTRL write only takes effect next cycle.
  assign tick  = en && (pre == PRE_LAST);
  assign match = tick && (count == cmp);

  // NOTE: sequential state uses non-blocking (<=) so every flop sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre          <= '0;
      count        <= '0;
      cmp          <= '1;
      en           <= 1'b0;
      clr_on_match <= 1'b0;
      irq_en       <= 1'b0;
      flag         <= 1'b0;
    end else begin
      pre <= (en && !tick) ? pre + 1'b1 : '0;

      // A CPU load of COUNT overrides both the increment and the clear-on-match.
      if (count_we)
        count <= wdata;
      else if (tick)
        count <= (match && clr_on_match) ? '0 : count + 1'b1;

      if (cmp_we)
        cmp <= wdata;

      // Setting on a match wins over a same-cycle write-1-to-clear.
      if (match)
        flag <= 1'b1;
      else if (ctrl_we && wdata[CTRL_FLAG])
        flag <= 1'b0;

      if (ctrl_we) begin
        en           <= wdata[CTRL_EN];
        clr_on_match <= wdata[CTRL_CLR];
        irq_en       <= wdata[CTRL_IRQEN];
      end
    end
  end

  // NOTE: assign a default first so no branch can leave a bit unassigned (no latch).
  always_comb begin
    ctrl             = '0;
    ctrl[CTRL_EN]    = en;
    ctrl[CTRL_CLR]   = clr_on_match;
    ctrl[CTRL_FLAG]  = flag;
    ctrl[CTRL_IRQEN] = irq_en;
  end

  assign irq = flag & irq_en;

endmodule

// File: rtl/data_bus.sv
// Data-side bus fabric: decodes core word accesses to the external RAM or the
// register bank (LEDs, switches, scratch, timer). Reads combinational, writes on clk.
module data_bus
  import data_bus_pkg::*;
#(
  parameter int          RAM_AW    = 14,
  parameter logic [15:0] MMIO_BASE = DEFAULT_MMIO_BASE,
  parameter int          PRESCALE  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memwrite,
  input  logic [31:0]       addr,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  input  logic [15:0]       switches,
  output logic [15:0]       leds,
  output logic              irq
);

  bus_sel_e    sel;
  logic [31:0] scratch;
  logic [15:0] sw_meta;
  logic [15:0] sw_sync;
  logic [31:0] t_count;
  logic [31:0] t_cmp;
  logic [31:0] t_ctrl;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^addr[1:0];

  always_comb begin
    sel = SEL_NONE;
    if (addr[31:RAM_AW+2] == '0)
      sel = SEL_RAM;
    else if (addr[31:16] == MMIO_BASE)
      sel = decode_offset({addr[7:2], 2'b00});
  end

  assign ram_we    = memwrite && (sel == SEL_RAM);
  assign ram_addr  = addr[RAM_AW+1:2];
  assign ram_wdata = writedata;

  always_ff @(posedge clk) begin
    if (rst) begin
      leds    <= '0;
      scratch <= '0;
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      if (memwrite && (sel == SEL_LED))
        leds <= writedata[15:0];
      if (memwrite && (sel == SEL_SCRATCH))
        scratch <= writedata;
      // Two-flop synchroniser for the asynchronous board switches.
      sw_meta <= switches;
      sw_sync <= sw_meta;
    end
  end

  mmio_timer #(
    .PRESCALE(PRESCALE)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .wdata    (writedata),
    .count_we (memwrite && (sel == SEL_COUNT)),
    .cmp_we   (memwrite && (sel == SEL_CMP)),
    .ctrl_we  (memwrite && (sel == SEL_CTRL)),
    .count    (t_count),
    .cmp      (t_cmp),
    .ctrl     (t_ctrl),
    .irq      (irq)
  );

  always_comb begin
    readdata = '0;
    case (sel)
      SEL_RAM:     readdata = ram_rdata;
      SEL_LED:     readdata = {16'h0000, leds};
      SEL_SW:      readdata = {16'h0000, sw_sync};
      SEL_COUNT:   readdata = t_count;
      SEL_CMP:     readdata = t_cmp;
      SEL_CTRL:    readdata = t_ctrl;
      SEL_SCRATCH: readdata = scratch;
      default:     readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_data_bus.sv
// Self-checking bench for data_bus: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_data_bus;

  localparam int RAM_AW   = 14;
  localparam int PRESCALE = 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              memwrite = 1'b0;
  logic [31:0]       addr = '0;
  logic [31:0]       writedata = '0;
  logic [31:0]       readdata;
  logic              ram_we;
  logic [RAM_AW-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata = '0;
  logic [15:0]       switches = '0;
  logic [15:0]       leds;
  logic              irq;

  always #5 clk = ~clk;

  data_bus #(
    .RAM_AW   (RAM_AW),
    .MMIO_BASE(16'hBFD0),
    .PRESCALE (PRESCALE)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .memwrite (memwrite),
    .addr     (addr),
    .writedata(writedata),
    .readdata (readdata),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata),
    .switches (switches),
    .leds     (leds),
    .irq      (irq)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model of the architecturally visible state.
  bit [15:0] m_leds, m_sw1, m_sw2;
  bit [31:0] m_scratch, m_count, m_cmp;
  bit        m_en, m_clr, m_irqen, m_flag;
  int        m_pre;
  bit        model_valid = 1'b0;

  function automatic bit in_ram(input logic [31:0] a);
    return (a >> (RAM_AW + 2)) == 0;
  endfunction

  function automatic bit in_mmio(input logic [31:0] a);
    return (a >> 16) == 32'h0000_BFD0;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a, input logic [31:0] rrd);
    int off;
    if (in_ram(a)) return rrd;
    if (!in_mmio(a)) return 32'h0;
    off = int'(a & 32'hFC);
    case (off)
      'h00: return {16'h0, m_leds};
      'h04: return {16'h0, m_sw2};
      'h08: return m_count;
      'h0C: return m_cmp;
      'h10: return {28'h0, m_irqen, m_flag, m_clr, m_en};
      'h14: return m_scratch;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_update(input bit r, input bit mw, input logic [31:0] a,
                              input logic [31:0] wd, input logic [15:0] sw);
    bit        wr_mmio, tick, match;
    int        off;
    bit [31:0] n_count;
    bit        n_flag;
    if (r) begin
      m_leds = 0; m_scratch = 0; m_count = 0; m_cmp = 32'hFFFF_FFFF;
      m_en = 0; m_clr = 0; m_irqen = 0; m_flag = 0; m_pre = 0;
      m_sw1 = 0; m_sw2 = 0;
      return;
    end
    wr_mmio = mw && in_mmio(a) && !in_ram(a);
    off     = int'(a & 32'hFC);
    tick    = m_en && (m_pre == PRESCALE - 1);
    match   = tick && (m_count == m_cmp);
    n_count = m_count;
    if (tick) n_count = (match && m_clr) ? 32'h0 : m_count + 1;
    if (wr_mmio && off == 'h08) n_count = wd;
    n_flag = m_flag;
    if (wr_mmio && off == 'h10 && wd[2]) n_flag = 0;
    if (match) n_flag = 1;
    m_pre   = m_en ? (tick ? 0 : m_pre + 1) : 0;
    m_count = n_count;
    m_flag  = n_flag;
    if (wr_mmio && off == 'h0C) m_cmp = wd;
    if (wr_mmio && off == 'h10) begin
      m_en = wd[0]; m_clr = wd[1]; m_irqen = wd[3];
    end
    if (wr_mmio && off == 'h00) m_leds = wd[15:0];
    if (wr_mmio && off == 'h14) m_scratch = wd;
    m_sw2 = m_sw1;
    m_sw1 = sw;
  endtask

  logic [31:0] s_rd, s_wd;
  logic [15:0] s_leds;
  logic [RAM_AW-1:0] s_ra;
  logic s_we, s_irq;
  logic [15:0] cur_sw = '0;

  // One bus cycle: drive at negedge, compare just after, advance model at posedge.
  task automatic do_cycle(input bit r, input bit mw, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rrd);
    @(negedge clk);
    rst = r; memwrite = mw; addr = a; writedata = wd; ram_rdata = rrd; switches = cur_sw;
    #1;
    s_rd = readdata; s_we = ram_we; s_ra = ram_addr; s_wd = ram_wdata;
    s_leds = leds; s_irq = irq;
    if (model_valid) begin
      check("readdata", readdata, model_read(a, rrd));
      check("ram_we", {31'h0, ram_we}, {31'h0, mw && in_ram(a)});
      check("ram_addr", {18'h0, ram_addr}, (a >> 2) & ((32'h1 << RAM_AW) - 1));
      check("ram_wdata", ram_wdata, wd);
      check("leds", {16'h0, leds}, {16'h0, m_leds});
      check("irq", {31'h0, irq}, {31'h0, m_flag & m_irqen});
    end
    @(posedge clk);
    model_update(r, mw, a, wd, cur_sw);
    if (r) model_valid = 1'b1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    do_cycle(1'b0, 1'b1, a, d, $urandom);
  endtask

  task automatic rd(input logic [31:0] a);
    do_cycle(1'b0, 1'b0, a, 32'h0, $urandom);
  endtask

  localparam logic [31:0] A_LED = 32'hBFD0_0000, A_SW = 32'hBFD0_0004,
                          A_COUNT = 32'hBFD0_0008, A_CMP = 32'hBFD0_000C,
                          A_CTRL = 32'hBFD0_0010, A_SCR = 32'hBFD0_0014;

  initial begin
    logic [31:0] a, wd;
    int cat, idx;
    bit r, mw;

    do_cycle(1'b1, 1'b0, 32'h0, 32'h0, 32'h0);
    do_cycle(1'b1, 1'b0, 32'h0, 32'h0, 32'h0);
    rd(A_LED);   check("rst_led", s_rd, 32'h0);
    rd(A_COUNT); check("rst_count", s_rd, 32'h0);
    rd(A_CMP);   check("rst_cmp", s_rd, 32'hFFFF_FFFF);
    rd(A_CTRL);  check("rst_ctrl", s_rd, 32'h0);
    check("rst_irq", {31'h0, s_irq}, 32'h0);

    // RAM path
    do_cycle(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h1234_5678);
    check("ram_we_lit", {31'h0, s_we}, 32'h1);
    check("ram_addr_lit", {18'h0, s_ra}, 32'h4);
    check("ram_wdata_lit", s_wd, 32'hDEAD_BEEF);
    check("ram_rd_lit", s_rd, 32'h1234_5678);

    // LED write/readback, switch synchroniser latency
    wr(A_LED, 32'hFFFF_A5A5);
    rd(A_LED);
    check("led_rd_lit", s_rd, 32'h0000_A5A5);
    check("leds_lit", {16'h0, s_leds}, 32'h0000_A5A5);
    cur_sw = 16'h00C3;
    rd(A_SW); check("sw_lat0", s_rd, 32'h0);
    rd(A_SW); check("sw_lat1", s_rd, 32'h0);
    rd(A_SW); check("sw_lat2", s_rd, 32'h0000_00C3);

    // Timer period: CMP=4, EN|CLR|IRQEN
    wr(A_CMP, 32'd4);
    wr(A_CTRL, 32'hB);
    for (int i = 0; i < 10; i++) begin
      rd(A_COUNT);
      check("period_count", s_rd, i % 5);
      check("period_irq", {31'h0, s_irq}, (i >= 5) ? 32'h1 : 32'h0);
    end

    // W1C off a match, then on a match
    wr(A_CTRL, 32'hF);
    rd(A_CTRL);  check("w1c_ctrl", s_rd, 32'hB);
    check("w1c_irq", {31'h0, s_irq}, 32'h0);
    rd(A_COUNT); check("w1c_count2", s_rd, 32'd2);
    rd(A_COUNT); check("w1c_count3", s_rd, 32'd3);
    wr(A_CTRL, 32'hF);
    rd(A_CTRL);  check("w1c_match_ctrl", s_rd, 32'hF);
    check("w1c_match_irq", {31'h0, s_irq}, 32'h1);

    // Write priority over tick, and wrap
    wr(A_CTRL, 32'h4);
    wr(A_CMP, 32'h0);
    wr(A_CTRL, 32'h1);
    wr(A_COUNT, 32'hFFFF_FFFF);
    rd(A_COUNT); check("prio_count", s_rd, 32'hFFFF_FFFF);
    rd(A_CTRL);  check("wrap_noflag", s_rd, 32'h1);
    rd(A_COUNT); check("wrap_count1", s_rd, 32'h1);
    check("wrap_irq_masked", {31'h0, s_irq}, 32'h0);
    rd(A_CTRL);  check("wrap_flag", s_rd, 32'h5);

    // Unmapped accesses
    wr(A_CTRL, 32'h4);
    rd(32'h1000_0000); check("unmap_rd", s_rd, 32'h0);
    rd(32'hBFD0_0040); check("unmap_mmio_rd", s_rd, 32'h0);
    wr(32'hBFD0_0040, 32'hFFFF_FFFF);
    check("unmap_we", {31'h0, s_we}, 32'h0);
    rd(A_SCR); check("unmap_scratch", s_rd, 32'h0);
    rd(A_LED); check("unmap_led", s_rd, 32'h0000_A5A5);
    wr(A_SCR, 32'h1234_5678);
    rd(A_SCR); check("scratch_rd", s_rd, 32'h1234_5678);

    // Reset mid-count
    wr(A_CTRL, 32'h1);
    rd(A_COUNT); rd(A_COUNT);
    do_cycle(1'b1, 1'b0, A_COUNT, 32'h0, 32'h0);
    rd(A_COUNT); check("mid_rst_count", s_rd, 32'h0);
    rd(A_CMP);   check("mid_rst_cmp", s_rd, 32'hFFFF_FFFF);
    rd(A_CTRL);  check("mid_rst_ctrl", s_rd, 32'h0);
    check("mid_rst_leds", {16'h0, s_leds}, 32'h0);
    rd(A_SCR);   check("mid_rst_scratch", s_rd, 32'h0);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      r   = ($urandom_range(0, 299) == 0);
      mw  = $urandom_range(0, 1) == 1;
      wd  = $urandom;
      cat = $urandom_range(0, 9);
      if (cat <= 2) begin
        a = $urandom & 32'h0000_FFFF;
      end else if (cat <= 7) begin
        idx = $urandom_range(0, 5);
        a = 32'hBFD0_0000 | (idx * 4) | $urandom_range(0, 3);
        if (idx == 2 || idx == 3) wd = $urandom_range(0, 12);
        if (idx == 2 && $urandom_range(0, 7) == 0) wd = 32'hFFFF_FFFF;
        if (idx == 4 && $urandom_range(0, 1) == 1) wd = wd | 32'h1;
      end else if (cat == 8) begin
        a = 32'hBFD0_0000 | ($urandom_range(6, 63) * 4);
      end else begin
        a = $urandom;
      end
      if ($urandom_range(0, 15) == 0) cur_sw = 16'($urandom);
      do_cycle(r, mw, a, wd, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_bus.md
# data_bus

Data-side bus fabric between the pipelined core's memory-stage port (memwrite, aluout, writedata, readdata) and the rest of the system. Decodes each word access to the external data RAM or to a small register bank: LEDs, switches, scratch and a 32-bit compare timer with interrupt. Reads are combinational, so the core still sees readdata in its memory stage. Writes commit on the rising clock edge.

## Interface

Parameters:
- RAM_AW, 14: RAM word-address width; RAM window is 2^RAM_AW words starting at 0x0000_0000.
- MMIO_BASE, 16'hBFD0: value of addr[31:16] that selects the register bank.
- PRESCALE, 1: timer ticks once every PRESCALE clocks; must be ≥1.

Ports:
- clk, in, 1: single clock; all state updates on its rising edge.
- rst, in, 1: synchronous, active-high reset.
- memwrite, in, 1: write strobe from the core's memory stage.
- addr, in, 32: byte address (core aluout); addr[1:0] is ignored.
- writedata, in, 32: store data.
- readdata, out, 32: load data; combinational from addr.
- ram_we, out, 1: RAM write enable.
- ram_addr, out, RAM_AW: addr[RAM_AW+1:2].
- ram_wdata, out, 32: equals writedata.
- ram_rdata, in, 32: RAM combinational read data.
- switches, in, 16: asynchronous board inputs.
- leds, out, 16: LED register.
- irq, out, 1: timer interrupt, level.

## Operation

- Decode:
  - RAM hit when addr[31:RAM_AW+2]==0.
  - MMIO hit when addr[31:16]==MMIO_BASE.
  - Anything else is unmapped: reads return 0, writes are dropped.
- ram_we = memwrite & RAM hit. RAM-hit readdata = ram_rdata.
- MMIO offsets, addr[7:0]:
  - 0x00 LED (RW): low 16 bits, upper bits read 0.
  - 0x04 SW (RO): 2-flop-synchronised switches, zero-extended.
  - 0x08 COUNT (RW): writes load the counter.
  - 0x0C CMP (RW).
  - 0x10 CTRL: bit0 EN, bit1 CLR_ON_MATCH, bit3 IRQ_EN (all RW); bit2 FLAG (read; write 1 clears); other bits read 0.
  - 0x14 SCRATCH (RW).
  - Other offsets inside the MMIO window behave as unmapped.
- Timer:
  - Prescaler counts 0..PRESCALE-1 while EN=1. It is forced to 0 while EN=0.
  - A tick occurs when the prescaler is at PRESCALE-1.
  - On a tick, COUNT increments and wraps 0xFFFF_FFFF→0.
  - Match is COUNT==CMP, evaluated on a tick cycle before the increment.
  - On a match, FLAG is set. If CLR_ON_MATCH=1, COUNT loads 0 instead of incrementing.
- irq = FLAG & IRQ_EN, registered-state only; no combinational path from addr.
- Simultaneous events:
  - A CPU write to COUNT beats a tick or clear in the same cycle.
  - A FLAG set (match) beats a W1C in the same cycle.
  - A write to CTRL applies EN, CLR_ON_MATCH and IRQ_EN in the next cycle. A tick in the write cycle still uses the old CTRL.
- Reset values:
  - leds=0, COUNT=0, CMP=0xFFFF_FFFF, CTRL=0, SCRATCH=0.
  - Prescaler 0, synchroniser flops 0, irq=0.
- Reset mid-operation: all registers return to reset values on the next edge. ram_we stays a pure decode of memwrite, so the core must hold memwrite low during rst.

## Timing

- Read latency 0: readdata is valid in the same cycle addr is stable.
- Write latency 1: a register write is visible on reads in the cycle after the memwrite edge. A write-then-read in back-to-back cycles returns the new value.
- Switches reach SW two clocks after a stable input change.
- FLAG and irq rise one edge after the matching tick.
- With PRESCALE=1 and CLR_ON_MATCH=1, the timer period is CMP+1 clocks.

## Structure

- Shared package data_bus_pkg holds:
  - Offset constants: OFF_LED, OFF_SW, OFF_COUNT, OFF_CMP, OFF_CTRL, OFF_SCRATCH.
  - CTRL bit indices: CTRL_EN=0, CTRL_CLR=1, CTRL_FLAG=2, CTRL_IRQEN=3.
  - Default MMIO_BASE.
- One sub-module, mmio_timer, owns the prescaler, COUNT, CMP, CTRL and FLAG. Its inputs are decoded write strobes plus writedata; its outputs are register read values and irq.
- The top level holds the decode, the read mux, LED and SCRATCH, and the switch synchroniser.

## Test plan

- RAM path:
  - Stimulus: memwrite=1, addr=0x0000_0010, writedata=0xDEAD_BEEF.
  - Response: ram_we=1, ram_addr=4, ram_wdata=0xDEAD_BEEF; with ram_rdata=0x1234_5678 driven, readdata=0x1234_5678.
- LED/SW:
  - Stimulus: write 0xFFFF_A5A5 to 0xBFD0_0000, then read it back; switches=0x00C3 held for 2 clocks, then read 0xBFD0_0004.
  - Response: leds=0xA5A5; LED read returns 0x0000_A5A5; SW read returns 0x0000_00C3.
- Timer period:
  - Stimulus: PRESCALE=1; CMP=4; CTRL=0xB (EN, CLR_ON_MATCH, IRQ_EN).
  - Response: COUNT cycles 0..4; FLAG sets every 5 clocks; irq=1 from the first match.
- W1C:
  - Stimulus: write CTRL=0xF (W1C on FLAG) while no match.
  - Response: FLAG=0 and irq=0 next cycle.
  - Stimulus: issue the same W1C on a match cycle.
  - Response: FLAG stays 1.
- Write priority and wrap:
  - Stimulus: EN=1, CMP=0, CLR_ON_MATCH=0; write COUNT=0xFFFF_FFFF.
  - Response: the write wins over the tick; next tick COUNT=0 and FLAG stays 0; on the following tick COUNT==CMP, so FLAG sets and COUNT becomes 1.
- Unmapped and reset:
  - Stimulus: read 0x1000_0000 and 0xBFD0_0040; write 0xBFD0_0040.
  - Response: both reads return 0 and no state changes.
  - Stimulus: assert rst mid-count.
  - Response: COUNT=0, CMP=0xFFFF_FFFF, CTRL=0, leds=0 after one edge.
